tri_fetch: RTL and testbench



---
 rtl/transform_pkg.sv | 11 +
 rtl/tri_fetch_pkg.sv | 27 ++
 rtl/vertex_pkg.sv | 10 +
 rtl/tri_fetch.sv | 182 ++++++++++++++++++
 tb/tb_tri_fetch.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/transform_pkg.sv
// Per-instance transform record held in the raster memory.
package transform_pkg;

  typedef struct packed {
    logic [15:0] m00;
    logic [15:0] m11;
    logic [15:0] tx;
    logic [15:0] ty;
  } transform_t;

endpackage

// File: rtl/tri_fetch_pkg.sv
// Shared state type and index-triple field layout for the triangle fetcher.
package tri_fetch_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INST_RD,
    ST_INST_LATCH,
    ST_TRI_RD,
    ST_TRI_LATCH,
    ST_V0,
    ST_V1,
    ST_V2,
    ST_V3,
    ST_OUT,
    ST_NEXT_INST
  } fetch_state_t;

  // Field numbers inside a packed index triple; i0 sits in the low bits.
  localparam int IDX_F0 = 0;
  localparam int IDX_F1 = 1;
  localparam int IDX_F2 = 2;

  function automatic int idx_lsb(input int field, input int vidx_w);
    return field * vidx_w;
  endfunction

endpackage

// File: rtl/vertex_pkg.sv
// Vertex record shared by the raster memory and the transform/raster stage.
package vertex_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vertex_t;

endpackage

// File: rtl/tri_fetch.sv
// Frame-side reader: walks instances and their triangle lists, fetches three
// vertices plus the instance transform, and hands out one triangle per handshake.
module tri_fetch
  import tri_fetch_pkg::*;
  import vertex_pkg::*;
  import transform_pkg::*;
#(
  parameter int MAX_INST = 256,
  parameter int IID_W    = $clog2(MAX_INST),
  parameter int MAX_VERT = 8192,
  parameter int VA_W     = $clog2(MAX_VERT),
  parameter int MAX_TRI  = 8192,
  parameter int TA_W     = $clog2(MAX_TRI),
  parameter int VIDX_W   = 8,
  parameter int TIDX_W   = 8,
  parameter int TRI_W    = 3 * VIDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [IID_W:0]    num_inst,
  output logic              busy,
  output logic              frame_done,
  output logic [IID_W-1:0]  inst_id_rd,
  output logic [TA_W-1:0]   tri_addr_rd,
  output logic [VA_W-1:0]   vert_addr_rd,
  input  logic [VA_W-1:0]   vert_base_in,
  input  logic [VIDX_W-1:0] vert_count_in,
  input  logic [TA_W-1:0]   tri_base_in,
  input  logic [TIDX_W-1:0] tri_count_in,
  input  logic [TRI_W-1:0]  idx_tri_in,
  input  vertex_t           vert_in,
  input  transform_t        transform_in,
  output logic              out_valid,
  input  logic              out_ready,
  output vertex_t           out_v0,
  output vertex_t           out_v1,
  output vertex_t           out_v2,
  output transform_t        out_transform,
  output logic [IID_W-1:0]  out_inst_id,
  output logic              out_idx_err
);

  localparam int I0_LSB = idx_lsb(IDX_F0, VIDX_W);
  localparam int I1_LSB = idx_lsb(IDX_F1, VIDX_W);
  localparam int I2_LSB = idx_lsb(IDX_F2, VIDX_W);

  fetch_state_t      state;
  logic [IID_W:0]    num_inst_q;
  logic [IID_W:0]    inst_ctr;
  logic [VA_W-1:0]   vbase;
  logic [VIDX_W-1:0] vcount;
  logic [TA_W-1:0]   tbase;
  logic [TIDX_W-1:0] tcount;
  logic [TIDX_W-1:0] tri_ctr;
  logic [VIDX_W-1:0] idx1;
  logic [VIDX_W-1:0] idx2;

  logic [VIDX_W-1:0] i0_in;
  logic [VIDX_W-1:0] i1_in;
  logic [VIDX_W-1:0] i2_in;
  logic [TIDX_W:0]   tri_next;
  logic [IID_W:0]    inst_next;

  assign i0_in     = idx_tri_in[I0_LSB +: VIDX_W];
  assign i1_in     = idx_tri_in[I1_LSB +: VIDX_W];
  assign i2_in     = idx_tri_in[I2_LSB +: VIDX_W];
  assign tri_next  = {1'b0, tri_ctr} + (TIDX_W+1)'(1);
  assign inst_next = inst_ctr + (IID_W+1)'(1);

  // Vertex reads are pipelined: each address issued one state ahead of the capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      num_inst_q    <= '0;
      inst_ctr      <= '0;
      vbase         <= '0;
      vcount        <= '0;
      tbase         <= '0;
      tcount        <= '0;
      tri_ctr       <= '0;
      idx1          <= '0;
      idx2          <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      inst_id_rd    <= '0;
      tri_addr_rd   <= '0;
      vert_addr_rd  <= '0;
      out_valid     <= 1'b0;
      out_v0        <= '0;
      out_v1        <= '0;
      out_v2        <= '0;
      out_transform <= '0;
      out_inst_id   <= '0;
      out_idx_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            num_inst_q <= num_inst;
            if (num_inst == '0) begin
              frame_done <= 1'b1;
            end else begin
              inst_ctr   <= '0;
              inst_id_rd <= '0;
              busy       <= 1'b1;
              state      <= ST_INST_RD;
            end
          end
        end
        ST_INST_RD: state <= ST_INST_LATCH;
        ST_INST_LATCH: begin
          vbase         <= vert_base_in;
          vcount        <= vert_count_in;
          tbase         <= tri_base_in;
          tcount        <= tri_count_in;
          out_transform <= transform_in;
          out_inst_id   <= inst_id_rd;
          if (tri_count_in == '0) begin
            state <= ST_NEXT_INST;
          end else begin
            tri_ctr     <= '0;
            tri_addr_rd <= tri_base_in;
            state       <= ST_TRI_RD;
          end
        end
        ST_TRI_RD: state <= ST_TRI_LATCH;
        ST_TRI_LATCH: begin
          idx1         <= i1_in;
          idx2         <= i2_in;
          out_idx_err  <= (i0_in >= vcount) || (i1_in >= vcount) || (i2_in >= vcount);
          vert_addr_rd <= vbase + VA_W'(i0_in);
          state        <= ST_V0;
        end
        ST_V0: begin
          vert_addr_rd <= vbase + VA_W'(idx1);
          state        <= ST_V1;
        end
        ST_V1: begin
          out_v0       <= vert_in;
          vert_addr_rd <= vbase + VA_W'(idx2);
          state        <= ST_V2;
        end
        ST_V2: begin
          out_v1 <= vert_in;
          state  <= ST_V3;
        end
        ST_V3: begin
          out_v2    <= vert_in;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (tri_next < {1'b0, tcount}) begin
              tri_ctr     <= tri_next[TIDX_W-1:0];
              tri_addr_rd <= tbase + TA_W'(tri_next);
              state       <= ST_TRI_RD;
            end else begin
              state <= ST_NEXT_INST;
            end
          end
        end
        ST_NEXT_INST: begin
          if (inst_next < num_inst_q) begin
            inst_ctr   <= inst_next;
            inst_id_rd <= inst_id_rd + IID_W'(1);
            state      <= ST_INST_RD;
          end else begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_fetch.sv
// Scoreboard bench for tri_fetch: directed frames against a modelled raster memory.
module tb_tri_fetch;
  import vertex_pkg::*;
  import transform_pkg::*;

  localparam int IID_W  = 8;
  localparam int VA_W   = 13;
  localparam int TA_W   = 13;
  localparam int VIDX_W = 8;
  localparam int TIDX_W = 8;
  localparam int TRI_W  = 24;

  typedef struct packed {
    logic [IID_W-1:0] id;
    vertex_t          v0;
    vertex_t          v1;
    vertex_t          v2;
    transform_t       xf;
    logic             err;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              frame_start;
  logic [IID_W:0]    num_inst;
  logic              busy;
  logic              frame_done;
  logic [IID_W-1:0]  inst_id_rd;
  logic [TA_W-1:0]   tri_addr_rd;
  logic [VA_W-1:0]   vert_addr_rd;
  logic [VA_W-1:0]   vert_base_in;
  logic [VIDX_W-1:0] vert_count_in;
  logic [TA_W-1:0]   tri_base_in;
  logic [TIDX_W-1:0] tri_count_in;
  logic [TRI_W-1:0]  idx_tri_in;
  vertex_t           vert_in;
  transform_t        transform_in;
  logic              out_valid;
  logic              out_ready;
  vertex_t           out_v0;
  vertex_t           out_v1;
  vertex_t           out_v2;
  transform_t        out_transform;
  logic [IID_W-1:0]  out_inst_id;
  logic              out_idx_err;

  logic [VA_W-1:0]   d_vbase [256];
  logic [VIDX_W-1:0] d_vcount[256];
  logic [TA_W-1:0]   d_tbase [256];
  logic [TIDX_W-1:0] d_tcount[256];
  logic [TRI_W-1:0]  tri_mem [8192];
  vertex_t           vert_mem[8192];

  exp_t exp_q[$];
  exp_t act_v;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   xfers = 0;
  int   dones = 0;
  int   wrap_hits = 0;

  tri_fetch #(.MAX_INST(256), .MAX_VERT(8192), .MAX_TRI(8192), .VIDX_W(VIDX_W), .TIDX_W(TIDX_W)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .num_inst(num_inst),
    .busy(busy), .frame_done(frame_done),
    .inst_id_rd(inst_id_rd), .tri_addr_rd(tri_addr_rd), .vert_addr_rd(vert_addr_rd),
    .vert_base_in(vert_base_in), .vert_count_in(vert_count_in),
    .tri_base_in(tri_base_in), .tri_count_in(tri_count_in),
    .idx_tri_in(idx_tri_in), .vert_in(vert_in), .transform_in(transform_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_v0(out_v0), .out_v1(out_v1), .out_v2(out_v2),
    .out_transform(out_transform), .out_inst_id(out_inst_id), .out_idx_err(out_idx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vertex_t vert_of(input int a);
    vertex_t v;
    v.x = 16'(a);
    v.y = 16'(a) ^ 16'hA5A5;
    v.z = 16'(a) + 16'h0300;
    return v;
  endfunction

  function automatic transform_t xform_of(input int id);
    transform_t t;
    t.m00 = 16'h1000 + 16'(id);
    t.m11 = 16'h2000 + 16'(id);
    t.tx  = 16'h3000 + 16'(id);
    t.ty  = 16'h4000 + 16'(id);
    return t;
  endfunction

  // Descriptors are combinational; triangle, vertex and transform reads take one cycle.
  assign vert_base_in  = d_vbase[inst_id_rd];
  assign vert_count_in = d_vcount[inst_id_rd];
  assign tri_base_in   = d_tbase[inst_id_rd];
  assign tri_count_in  = d_tcount[inst_id_rd];

  always @(posedge clk) begin
    idx_tri_in   <= tri_mem[tri_addr_rd];
    vert_in      <= vert_mem[vert_addr_rd];
    transform_in <= xform_of(int'(inst_id_rd));
  end

  task automatic check_output(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_inst(input int id, input int vb, input int vc, input int tb, input int tc);
    d_vbase[id]  = VA_W'(vb);
    d_vcount[id] = VIDX_W'(vc);
    d_tbase[id]  = TA_W'(tb);
    d_tcount[id] = TIDX_W'(tc);
  endtask

  task automatic set_tri(input int addr, input int i0, input int i1, input int i2);
    tri_mem[addr] = {VIDX_W'(i2), VIDX_W'(i1), VIDX_W'(i0)};
  endtask

  task automatic push_exp(input int id, input int vb, input int i0, input int i1, input int i2,
                          input logic err);
    exp_t e;
    e.id  = IID_W'(id);
    e.v0  = vert_of((vb + i0) % 8192);
    e.v1  = vert_of((vb + i1) % 8192);
    e.v2  = vert_of((vb + i2) % 8192);
    e.xf  = xform_of(id);
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic start_frame(input int num);
    step();
    num_inst    = (IID_W+1)'(num);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!frame_done && n < 1000) begin
      step();
      n++;
    end
    if (!frame_done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s_timeout: frame_done still 0 after %0d cycles, expected a pulse", name, n);
    end
    step();
  endtask

  task automatic apply_stimulus(input string name, input int num);
    start_frame(num);
    wait_done(name);
  endtask

  // Monitor: every presented triangle is compared to the scoreboard head, popped on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          act_v = '{out_inst_id, out_v0, out_v1, out_v2, out_transform, out_idx_err};
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL tri_extra: got %h, expected no triangle", act_v);
          end else if (act_v !== exp_q[0]) begin
            tests_failed++;
            $display("[TB] FAIL tri_data: got %h, expected %h", act_v, exp_q[0]);
          end
          if (out_ready) begin
            xfers++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end
        end
        if (frame_done) begin
          dones++;
          check_output("done_alone", int'(out_valid), 0);
        end
        if (vert_addr_rd == VA_W'(3)) wrap_hits++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, tri_n, valid_n, done_n, x0, d0, w0;
    for (int a = 0; a < 8192; a++) begin
      vert_mem[a] = vert_of(a);
      tri_mem[a]  = '0;
    end
    for (int i = 0; i < 256; i++) set_inst(i, 0, 0, 0, 0);
    rst = 1'b1; frame_start = 1'b0; num_inst = '0; out_ready = 1'b0;
    repeat (3) step();
    check_output("rst_valid", int'(out_valid), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(frame_done), 0);
    check_output("rst_addrs", int'(inst_id_rd) + int'(tri_addr_rd) + int'(vert_addr_rd), 0);
    check_output("rst_out_data", int'((out_v0 != '0) || (out_v1 != '0) || (out_v2 != '0) ||
                                      (out_transform != '0) || (out_inst_id != '0) || out_idx_err), 0);
    rst = 1'b0;
    step();

    // Single instance, single triangle: latency from frame_start and from TRI_RD.
    set_inst(0, 100, 3, 20, 1);
    set_tri(20, 0, 1, 2);
    push_exp(0, 100, 0, 1, 2, 1'b0);
    out_ready = 1'b1;
    x0 = xfers; d0 = dones;
    start_frame(1);
    n = 1; tri_n = -1;
    while (!out_valid && n < 100) begin
      if (tri_n < 0 && tri_addr_rd == TA_W'(20)) tri_n = n;
      step();
      n++;
    end
    valid_n = n;
    while (!frame_done && n < 100) begin
      step();
      n++;
    end
    done_n = n;
    step();
    check_output("t1_tri_rd_at", tri_n, 3);
    check_output("t1_tri_to_valid", valid_n - tri_n, 6);
    check_output("t1_valid_at", valid_n, 9);
    check_output("t1_done_after_hs", done_n - valid_n, 2);
    check_output("t1_xfers", xfers - x0, 1);
    check_output("t1_dones", dones - d0, 1);

    // Two instances with 3 and 2 triangles, ready always high.
    set_inst(0, 200, 16, 40, 3);
    set_tri(40, 0, 1, 2); set_tri(41, 3, 4, 5); set_tri(42, 2, 1, 0);
    set_inst(1, 500, 8, 60, 2);
    set_tri(60, 7, 6, 5); set_tri(61, 0, 0, 1);
    push_exp(0, 200, 0, 1, 2, 1'b0);
    push_exp(0, 200, 3, 4, 5, 1'b0);
    push_exp(0, 200, 2, 1, 0, 1'b0);
    push_exp(1, 500, 7, 6, 5, 1'b0);
    push_exp(1, 500, 0, 0, 1, 1'b0);
    x0 = xfers; d0 = dones;
    apply_stimulus("t2", 2);
    check_output("t2_xfers", xfers - x0, 5);
    check_output("t2_dones", dones - d0, 1);
    check_output("t2_q_empty", exp_q.size(), 0);

    // Back-pressure: outputs and read addresses hold while out_ready is low.
    set_inst(0, 300, 4, 80, 1);
    set_tri(80, 3, 2, 1);
    push_exp(0, 300, 3, 2, 1, 1'b0);
    out_ready = 1'b0;
    x0 = xfers;
    start_frame(1);
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check_output("t3_stall_valid", int'(out_valid), 1);
      check_output("t3_stall_vaddr", int'(vert_addr_rd), 301);
      check_output("t3_stall_taddr", int'(tri_addr_rd), 80);
      step();
    end
    check_output("t3_no_xfer_stalled", xfers - x0, 0);
    out_ready = 1'b1;
    wait_done("t3");
    check_output("t3_xfers", xfers - x0, 1);

    // Empty middle instance is skipped; then a zero-instance frame.
    set_inst(0, 10, 3, 0, 1);
    set_tri(0, 0, 1, 2);
    set_inst(1, 900, 4, 30, 0);
    set_inst(2, 20, 3, 5, 1);
    set_tri(5, 2, 2, 2);
    push_exp(0, 10, 0, 1, 2, 1'b0);
    push_exp(2, 20, 2, 2, 2, 1'b0);
    x0 = xfers; d0 = dones;
    apply_stimulus("t4", 3);
    check_output("t4_xfers", xfers - x0, 2);
    check_output("t4_dones", dones - d0, 1);
    x0 = xfers; d0 = dones;
    start_frame(0);
    check_output("t4_zero_done", int'(frame_done), 1);
    check_output("t4_zero_busy", int'(busy), 0);
    step();
    check_output("t4_zero_pulse_len", int'(frame_done), 0);
    check_output("t4_zero_xfers", xfers - x0, 0);
    check_output("t4_zero_dones", dones - d0, 1);

    // Vertex and triangle address wrap; out-of-range index still emitted with error flag.
    set_inst(0, 8190, 8, 8191, 2);
    set_tri(8191, 5, 0, 1);
    set_tri(0, 9, 1, 2);
    push_exp(0, 8190, 5, 0, 1, 1'b0);
    push_exp(0, 8190, 9, 1, 2, 1'b1);
    x0 = xfers; w0 = wrap_hits;
    apply_stimulus("t5", 1);
    check_output("t5_wrap_addr_seen", int'(wrap_hits > w0), 1);
    check_output("t5_xfers", xfers - x0, 2);

    // Reset while fetching v1, then a clean frame.
    set_inst(0, 100, 3, 20, 1);
    set_tri(20, 0, 1, 2);
    x0 = xfers;
    start_frame(1);
    n = 1;
    while (n < 6) begin
      step();
      n++;
    end
    check_output("t6_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    step();
    check_output("t6_rst_valid", int'(out_valid), 0);
    check_output("t6_rst_busy", int'(busy), 0);
    check_output("t6_rst_vaddr", int'(vert_addr_rd), 0);
    rst = 1'b0;
    step();
    check_output("t6_no_xfer_aborted", xfers - x0, 0);
    push_exp(0, 100, 0, 1, 2, 1'b0);
    x0 = xfers; d0 = dones;
    apply_stimulus("t6", 1);
    check_output("t6_xfers", xfers - x0, 1);
    check_output("t6_dones", dones - d0, 1);
    check_output("final_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
